vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_scanout_tick_delay.sv | 41 ++++
 rtl/vga_scanout.sv | 128 ++++++++++++
 tb/tb_vga_scanout.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants, total-count helpers and the
// per-coordinate control bundle carried down the scanout delay line.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
    } ctrl_t;

    // Blank, both syncs deasserted: what the delay line holds out of reset.
    localparam ctrl_t CTRL_RESET = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_scanout_tick_delay.sv
// DEPTH-stage enabled shift register; also exposes the input of the last
// stage so a consumer can register something alongside it.
module tick_delay #(
    parameter int               DEPTH       = 1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_tap_input
            assign tap = d;
        end else begin : g_tap_stage
            assign tap = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA raster counters and scanout: presents x/y to the sprite clusters, samples
// the returned pixel and drives registered RGB444 plus active-low syncs.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COLOR_WIDTH = 12,
    parameter int CLK_DIV     = 4,
    parameter int PIPE_DEPTH  = 1,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [DATA_WIDTH-1:0]  x,
    output logic [DATA_WIDTH-1:0]  y,
    input  logic [COLOR_WIDTH-1:0] pixel,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [31:0]   h32;
    logic [31:0]   v32;
    logic          tick;
    logic          h_last;
    logic          v_last;
    ctrl_t         cur;
    ctrl_t         tap;
    ctrl_t         del;
    logic          unused_ctrl;

    assign tick   = (div == DW'(CLK_DIV - 1));
    assign h_last = (h == HW'(H_TOTAL - 1));
    assign v_last = (v == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // h and v move on the same tick edge, so y never shows a half-updated line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    assign x   = DATA_WIDTH'(h);
    assign y   = DATA_WIDTH'(v);
    assign h32 = 32'(h);
    assign v32 = 32'(v);

    always_comb begin
        cur      = CTRL_RESET;
        cur.act  = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        cur.hs_n = !((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC));
        cur.vs_n = !((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC));
    end

    tick_delay #(
        .DEPTH       (PIPE_DEPTH),
        .WIDTH       ($bits(ctrl_t)),
        .RESET_VALUE (CTRL_RESET)
    ) u_ctrl_delay (
        .clk (clk),
        .rst (rst),
        .en  (tick),
        .d   (cur),
        .q   (del),
        .tap (tap)
    );

    assign hsync = del.hs_n;
    assign vsync = del.vs_n;

    // The colour sampled at a tick belongs to the coordinate whose control
    // bits are about to enter the last delay stage, hence gating by tap.act.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                vga_r <= tap.act ? pixel[11:8] : 4'h0;
                vga_g <= tap.act ? pixel[7:4]  : 4'h0;
                vga_b <= tap.act ? pixel[3:0]  : 4'h0;
            end
        end
    end

    assign unused_ctrl = &{1'b0, tap.hs_n, tap.vs_n, del.act};

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two small-raster instances (PIPE_DEPTH 1 and 3) checked
// every clk against a time-based model, plus hand-computed literal points.
module tb_vga_scanout;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int DIV1 = 4;
    localparam int DIV3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, y1, x3, y3;
    logic [11:0] pix1, pix3;
    logic [3:0]  r1, g1, b1, r3, g3, b3;
    logic        hs1, vs1, hs3, vs3, fs1, fs3;

    int     checks = 0;
    int     errors = 0;
    longint t;

    always #5 clk = ~clk;

    // Clock edges seen since reset was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    vga_scanout #(
        .CLK_DIV(DIV1), .PIPE_DEPTH(1),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .pixel(pix1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    vga_scanout #(
        .CLK_DIV(DIV3), .PIPE_DEPTH(3),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut3 (
        .clk(clk), .rst(rst), .x(x3), .y(y3), .pixel(pix3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .hsync(hs3), .vsync(vs3), .frame_start(fs3)
    );

    function automatic logic [11:0] fn1(input longint h, input longint v);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(h % 16);
        b = 4'(v % 16);
        return 12'hABC ^ {a, b, 4'(a + b)};
    endfunction

    // Expected outputs after tt clk edges: period p = tt/div is the coordinate on
    // x/y, and the outputs show the coordinate p-depth (reset values before that).
    function automatic void model(input longint tt, input int div, input int depth, input bit pat,
                                  output longint ex, output longint ey, output logic [11:0] ergb,
                                  output logic ehs, output logic evs, output logic efs);
        longint p, c, hc, vc;
        p    = tt / div;
        ex   = p % HT;
        ey   = (p / HT) % VT;
        efs  = (tt > 0) && (tt % div == 0) && (p % (HT * VT) == 0);
        ehs  = 1'b1;
        evs  = 1'b1;
        ergb = 12'h000;
        c    = p - depth;
        if (c >= 0) begin
            hc  = c % HT;
            vc  = (c / HT) % VT;
            ehs = !(hc >= HA + HFP && hc < HA + HFP + HS);
            evs = !(vc >= VA + VFP && vc < VA + VFP + VS);
            if (hc < HA && vc < VA) ergb = pat ? 12'(hc) : fn1(hc, vc);
        end
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic checkOutput();
        longint ex, ey;
        logic [11:0] ergb;
        logic ehs, evs, efs;
        model(t, DIV1, 1, 1'b0, ex, ey, ergb, ehs, evs, efs);
        cmp("d1.x", x1, ex);
        cmp("d1.y", y1, ey);
        cmp("d1.rgb", {r1, g1, b1}, ergb);
        cmp("d1.hsync", hs1, ehs);
        cmp("d1.vsync", vs1, evs);
        cmp("d1.frame_start", fs1, efs);
        model(t, DIV3, 3, 1'b1, ex, ey, ergb, ehs, evs, efs);
        cmp("d3.x", x3, ex);
        cmp("d3.y", y3, ey);
        cmp("d3.rgb", {r3, g3, b3}, ergb);
        cmp("d3.hsync", hs3, ehs);
        cmp("d3.vsync", vs3, evs);
        cmp("d3.frame_start", fs3, efs);
    endtask

    // dut1 sees valid colour only on tick clks (noise otherwise); dut3 sees the
    // x of two periods back, held for the whole period.
    task automatic applyStimulus();
        longint q1, q3;
        q1 = t / DIV1;
        q3 = t / DIV3;
        if ((t + 1) % DIV1 == 0) pix1 = fn1(q1 % HT, (q1 / HT) % VT);
        else                     pix1 = 12'($urandom);
        pix3 = (q3 >= 2) ? 12'((q3 - 2) % HT) : 12'h000;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
        applyStimulus();
    endtask

    task automatic literalChecks();
        if (t == 3)    cmp("lit.x_before_first_tick", x1, 0);
        if (t == 4)    cmp("lit.x_first_tick", x1, 1);
        if (t == 4)    cmp("lit.rgb_first", {r1, g1, b1}, 12'hABC);
        if (t == 68)   cmp("lit.rgb_hblank", {r1, g1, b1}, 12'h000);
        if (t == 75)   cmp("lit.hsync_pre", hs1, 1);
        if (t == 76)   cmp("lit.hsync_fall", hs1, 0);
        if (t == 91)   cmp("lit.hsync_last_low", hs1, 0);
        if (t == 92)   cmp("lit.hsync_rise", hs1, 1);
        if (t == 95)   cmp("lit.x_line_end", x1, 23);
        if (t == 96)   cmp("lit.x_wrap", x1, 0);
        if (t == 96)   cmp("lit.y_wrap", y1, 1);
        if (t == 867)  cmp("lit.vsync_pre", vs1, 1);
        if (t == 868)  cmp("lit.vsync_fall", vs1, 0);
        if (t == 1059) cmp("lit.vsync_last_low", vs1, 0);
        if (t == 1060) cmp("lit.vsync_rise", vs1, 1);
        if (t == 1152) cmp("lit.frame_x", x1, 0);
        if (t == 1152) cmp("lit.frame_y", y1, 0);
        if (t == 1152) cmp("lit.frame_start", fs1, 1);
        if (t == 1153) cmp("lit.frame_start_end", fs1, 0);
        if (t == 30)   cmp("lit.d3_rgb", {r3, g3, b3}, 12'h007);
        if (t == 62)   cmp("lit.d3_hsync_pre", hs3, 1);
        if (t == 63)   cmp("lit.d3_hsync_fall", hs3, 0);
    endtask

    initial begin
        int     fs1_count, fs3_count;
        longint fs1_last, fs1_gap;
        bit     found;

        rst  = 1'b1;
        pix1 = 12'h000;
        pix3 = 12'h000;
        repeat (2) stepCycle();
        rst = 1'b0;

        for (int i = 0; i < 1200; i++) begin
            stepCycle();
            literalChecks();
        end

        // Walk to h=19, v=2 on dut1, where hsync is low mid-line.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            stepCycle();
            if ((t / DIV1) % (HT * VT) == 2 * HT + 19) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL seek_midline: got timeout, expected h=19 v=2");
        end

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("rst.x", x1, 0);
        cmp("rst.y", y1, 0);
        cmp("rst.rgb", {r1, g1, b1}, 12'h000);
        cmp("rst.hsync", hs1, 1);
        cmp("rst.vsync", vs1, 1);
        cmp("rst.frame_start", fs1, 0);
        cmp("rst.d3_x", x3, 0);
        cmp("rst.d3_hsync", hs3, 1);
        stepCycle();
        rst = 1'b0;

        fs1_count = 0;
        fs3_count = 0;
        fs1_last  = -1;
        fs1_gap   = 0;
        for (int i = 0; i < 3470; i++) begin
            stepCycle();
            literalChecks();
            if (fs1 === 1'b1) begin
                if (fs1_count > 0) begin
                    fs1_gap = t - fs1_last;
                    cmp("fs1.spacing", fs1_gap, HT * VT * DIV1);
                end
                fs1_last = t;
                fs1_count++;
            end
            if (fs3 === 1'b1) fs3_count++;
        end
        cmp("fs1.count", fs1_count, 3);
        cmp("fs3.count", fs3_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
